uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 216 +++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Byte-wide UART transmitter (8N1, idle high) fed by a small
//               power-of-two FIFO. A producer pushes bytes with a
//               valid/ready handshake. The transmitter drains the FIFO and
//               sends frames back to back, with no idle cycles between
//               frames while data is queued.
// Ports       : clk        - system clock, all logic on its rising edge
//               rst        - asynchronous, active-high reset
//               tx_data    - byte to send
//               tx_valid   - tx_data is valid
//               tx_ready   - a byte is accepted on this cycle's edge if valid
//               fifo_count - number of bytes currently buffered
//               tx_busy    - frame in progress or FIFO non-empty
//               uart_tx    - registered serial output
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 500000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx_busy,
    output logic                          uart_tx
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CNT_W        = PTR_W + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and next-state values
    // ------------------------------------------------------------------------
    state_t              state_q,   state_d;
    logic [BAUD_W-1:0]   baud_q,    baud_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [7:0]          shift_q,   shift_d;
    logic                tx_q,      tx_d;
    logic                busy_q,    busy_d;
    logic [PTR_W-1:0]    wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q,  rd_ptr_d;
    logic [CNT_W-1:0]    count_q,   count_d;

    logic [7:0]          mem_q [FIFO_DEPTH];

    logic                push_w;
    logic                pop_w;
    logic                fifo_empty_w;
    logic                bit_end_w;
    logic                ready_w;

    // ------------------------------------------------------------------------
    // FIFO bookkeeping
    // ------------------------------------------------------------------------
    // Readiness depends only on the registered count, so a pop on the same
    // edge never opens a slot for a push when the FIFO is full.
    assign ready_w      = (count_q < DEPTH_C);
    assign push_w       = tx_valid && ready_w;
    assign fifo_empty_w = (count_q == '0);
    assign bit_end_w    = (baud_q == BAUD_LAST);

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_w);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_w);
        count_d  = count_q + CNT_W'(push_w) - CNT_W'(pop_w);
    end

    // Storage is not reset; the pointers and count define its contents.
    // The write is suppressed while reset is held so nothing lands in it.
    always_ff @(posedge clk) begin
        if (push_w && !rst) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    // ------------------------------------------------------------------------
    // Transmit FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop_w     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                baud_d    = '0;
                bit_idx_d = '0;
                if (!fifo_empty_w) begin
                    pop_w   = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (bit_end_w) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            ST_DATA: begin
                if (bit_end_w) begin
                    baud_d    = '0;
                    // Index wraps 7 -> 0 naturally as the frame leaves DATA.
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            ST_STOP: begin
                if (bit_end_w) begin
                    baud_d = '0;
                    // Chain straight into the next frame when data is
                    // queued, so consecutive frames have no idle gap.
                    if (!fifo_empty_w) begin
                        pop_w   = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level follows the current state one cycle later; every bit keeps
    // its full width because the whole frame is shifted by the same cycle.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_q[bit_idx_q];
            default:  tx_d = 1'b1;
        endcase
    end

    // Busy is registered so that it falls together with the end of the
    // stop bit on the line.
    assign busy_d = (state_q != ST_IDLE) || (count_q != '0);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign tx_ready   = ready_w;
    assign fifo_count = count_q;
    assign tx_busy    = busy_q;
    assign uart_tx    = tx_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo. A line monitor decodes
//               every frame and compares it against a queue of expected
//               bytes. A vector table checks single-frame timing. Hand
//               sequences cover back-to-back frames, full FIFO, reset
//               mid-frame and a push on the last STOP cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int CPB   = 200;
    localparam int DEPTH = 16;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [4:0] fifo_count;
    logic       tx_busy;
    logic       uart_tx;

    uart_tx_fifo #(
        .CLK_FREQ   (100000000),
        .BAUD       (500000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .fifo_count (fifo_count),
        .tx_busy    (tx_busy),
        .uart_tx    (uart_tx)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Line monitor / scoreboard: samples mid-bit on the falling clock edge.
    // ------------------------------------------------------------------------
    logic       mon_active = 1'b0;
    int         mon_cnt    = 0;
    logic [9:0] mon_bits   = '0;

    initial begin : monitor
        int         k;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_active = 1'b0;
            end else if (!mon_active) begin
                if (uart_tx == 1'b0) begin
                    mon_active = 1'b1;
                    mon_cnt    = 0;
                end
            end else begin
                mon_cnt++;
                if (mon_cnt % CPB == CPB / 2) begin
                    k = mon_cnt / CPB;
                    mon_bits[k] = uart_tx;
                    if (k == 9) begin
                        mon_active = 1'b0;
                        chk("mon_framing", int'({mon_bits[9], mon_bits[0]}), 2);
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_errors++;
                            $display("FAIL mon_byte: got 0x%02h but no byte expected at %0t",
                                     mon_bits[8:1], $time);
                        end else begin
                            e = exp_q.pop_front();
                            chk("mon_byte", int'(mon_bits[8:1]), int'(e));
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    typedef struct {
        logic [7:0] data;
        logic [9:0] line;   // bit i = i-th line bit (start, d0..d7, stop)
    } vec_t;

    initial begin : stim
        vec_t       vecs[5];
        logic [9:0] cap;
        logic [19:0] cap20;
        int         bad;
        int         acc;
        int         cyc;
        int         maxcnt;
        int         acc_cyc[20];
        logic       r;

        vecs[0] = '{8'h55, 10'h2AA};
        vecs[1] = '{8'h00, 10'h200};
        vecs[2] = '{8'hFF, 10'h3FE};
        vecs[3] = '{8'h80, 10'h300};
        vecs[4] = '{8'h01, 10'h202};

        // ---------------- reset behaviour ----------------
        tick(2);
        chk("rst_line", int'(uart_tx), 1);
        chk("rst_ready", int'(tx_ready), 1);
        chk("rst_busy", int'(tx_busy), 0);
        tx_data  = 8'hAA;
        tx_valid = 1'b1;
        tick(3);
        chk("rst_no_accept", int'(fifo_count), 0);
        rst      = 1'b0;
        tx_valid = 1'b0;
        tick(1);
        chk("post_rst_count", int'(fifo_count), 0);

        // ---------------- idle ----------------
        bad = 0;
        for (int i = 0; i < 5000; i++) begin
            tick(1);
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        chk("idle_5000", bad, 0);

        // ---------------- single-frame vector table ----------------
        for (int v = 0; v < 5; v++) begin
            tx_data  = vecs[v].data;
            tx_valid = 1'b1;
            exp_q.push_back(vecs[v].data);
            @(posedge clk);
            #1;
            tx_valid = 1'b0;
            chk("vec_count_after_push", int'(fifo_count), 1);
            tick(1);
            chk("vec_line_before_start", int'(uart_tx), 1);
            chk("vec_count_after_pop", int'(fifo_count), 0);
            tick(1);
            chk("vec_start_latency", int'(uart_tx), 0);
            tick(CPB / 2);
            cap[0] = uart_tx;
            for (int k = 1; k < 10; k++) begin
                tick(CPB);
                cap[k] = uart_tx;
            end
            chk("vec_frame_line", int'(cap), int'(vecs[v].line));
            tick(CPB / 2 - 1);
            chk("vec_busy_in_stop", int'(tx_busy), 1);
            tick(1);
            chk("vec_busy_after_stop", int'(tx_busy), 0);
            chk("vec_line_idle", int'(uart_tx), 1);
            tick(5);
        end

        // ---------------- back-to-back ----------------
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        exp_q.push_back(8'hA5);
        @(posedge clk);
        #1;
        tx_data = 8'h3C;
        exp_q.push_back(8'h3C);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        chk("b2b_push_pop_count", int'(fifo_count), 1);
        tick(1);
        chk("b2b_start_latency", int'(uart_tx), 0);
        tick(CPB / 2);
        cap20[0] = uart_tx;
        for (int k = 1; k < 20; k++) begin
            tick(CPB);
            cap20[k] = uart_tx;
        end
        chk("b2b_line", int'(cap20), int'({1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0}));
        tick(CPB / 2 - 1);
        chk("b2b_busy_in_stop", int'(tx_busy), 1);
        tick(1);
        chk("b2b_busy_after", int'(tx_busy), 0);
        tick(10);

        // ---------------- full FIFO ----------------
        acc    = 0;
        cyc    = 0;
        maxcnt = 0;
        for (int i = 0; i < 20; i++) acc_cyc[i] = 0;
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        while (acc < 20 && cyc < 20000) begin
            r = tx_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (r) begin
                exp_q.push_back(8'(acc));
                acc_cyc[acc] = cyc;
                acc++;
                if (acc == 17) begin
                    chk("full_count_16", int'(fifo_count), DEPTH);
                    chk("full_ready_low", int'(tx_ready), 0);
                end
                if (acc < 20) tx_data = 8'(acc);
                else          tx_valid = 1'b0;
            end
            if (int'(fifo_count) > maxcnt) maxcnt = int'(fifo_count);
        end
        tx_valid = 1'b0;
        chk("full_all_accepted", acc, 20);
        chk("full_reopen_gap", acc_cyc[17] - acc_cyc[0], 2002);
        chk("full_slot_per_frame", acc_cyc[18] - acc_cyc[17], 2000);
        while (exp_q.size() != 0 && cyc < 50000) begin
            tick(1);
            cyc++;
            if (int'(fifo_count) > maxcnt) maxcnt = int'(fifo_count);
        end
        chk("full_drained", exp_q.size(), 0);
        chk("full_max_count", maxcnt, DEPTH);
        tick(CPB);
        chk("full_idle_busy", int'(tx_busy), 0);

        // ---------------- reset mid-frame ----------------
        tx_valid = 1'b1;
        tx_data  = 8'hF0; exp_q.push_back(8'hF0); @(posedge clk); #1;
        tx_data  = 8'h11; exp_q.push_back(8'h11); @(posedge clk); #1;
        tx_data  = 8'h22; exp_q.push_back(8'h22); @(posedge clk); #1;
        tx_data  = 8'h33; exp_q.push_back(8'h33); @(posedge clk); #1;
        tx_valid = 1'b0;
        // Now one cycle after the fourth accept; move to mid data bit 3.
        tick(2 + CPB / 2 + 4 * CPB - 3);
        chk("rstmid_line_bit3", int'(uart_tx), 0);
        chk("rstmid_count", int'(fifo_count), 3);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_line_high", int'(uart_tx), 1);
        chk("rstmid_count_zero", int'(fifo_count), 0);
        chk("rstmid_ready", int'(tx_ready), 1);
        chk("rstmid_busy", int'(tx_busy), 0);
        exp_q.delete();
        tick(3);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 3000; i++) begin
            tick(1);
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        chk("rstmid_quiet_after", bad, 0);

        // ---------------- push on last STOP cycle ----------------
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        exp_q.push_back(8'hC3);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tick(2000);
        chk("stopend_in_stop", int'(uart_tx), 1);
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        exp_q.push_back(8'h5A);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        chk("stopend_count", int'(fifo_count), 1);
        tick(1);
        chk("stopend_idle_cycle", int'(uart_tx), 1);
        chk("stopend_busy_held", int'(tx_busy), 1);
        tick(1);
        chk("stopend_start_latency", int'(uart_tx), 0);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 3000) begin
            tick(1);
            cyc++;
        end
        chk("stopend_drained", exp_q.size(), 0);
        tick(CPB);
        chk("final_busy", int'(tx_busy), 0);
        chk("final_line", int'(uart_tx), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
